fetch_wavepool: RTL and testbench
=================================

# fetch_wavepool

Per-wavefront instruction queue directly downstream of the instruction buffer. It captures each `fetchwave_ack`/`wave_instr`/`wave_tag` response into a small FIFO owned by the tagged wavefront. It then serves registered reads to the issue/decode stage. It also returns per-wavefront space status, so fetch never issues a request that cannot be stored.

## Interface
Parameters:
- `NUM_WF`, 8: number of wavefronts, one FIFO each.
- `DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `WFID_W`, 6: width of the wavefront id field.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `fetchwave_ack`  in  1  instruction response valid (single cycle).
- `wave_instr`  in  32  instruction word.
- `wave_tag`  in  39  tag fields:
  - [5:0] wfid.
  - [37:6] instruction PC.
  - [38] reserved; ignored.
- `wf_ready`  out  NUM_WF  bit i = 1 when FIFO i holds no more than DEPTH-2 entries.
- `wf_nonempty`  out  NUM_WF  bit i = 1 when FIFO i holds at least one entry.
- `rd_en`  in  1  read request.
- `rd_wfid`  in  WFID_W  wavefront to read.
- `rd_data_valid`  out  1  read data valid.
- `rd_instr`  out  32  instruction read.
- `rd_pc`  out  32  PC of the instruction read.
- `flush_en`  in  1  flush request.
- `flush_wfid`  in  WFID_W  wavefront to flush.
- `err`  out  2  sticky error flags: [0] overflow (write dropped), [1] underflow or bad-id read.

## Operation
- Write: on `fetchwave_ack`=1 with wfid < NUM_WF, push {pc, instr} into FIFO[wfid].
  - FIFO full, or wfid ≥ NUM_WF: drop the write and set err[0].
- Read: on `rd_en`=1, pop the head of FIFO[rd_wfid].
  - Data appears on `rd_instr`/`rd_pc` with `rd_data_valid`=1 in the next cycle.
  - FIFO empty, or rd_wfid ≥ NUM_WF: no pop, `rd_data_valid`=0 next cycle, set err[1].
- Same-cycle push and pop on the same FIFO, not empty: both occur, occupancy unchanged.
- Same-cycle push and pop on the same empty FIFO: the pop is an underflow; the push succeeds.
- Flush: on `flush_en`=1, FIFO[flush_wfid] pointers and count go to 0.
  - Flush beats a same-cycle write or read on that wfid: the write is dropped without error; the read returns `rd_data_valid`=0 without error.
  - Other wavefronts are unaffected.
- Fetch contract: fetch issues for wf i only when `wf_ready[i]`=1, and after a flush it issues nothing for that wf until its outstanding response has returned. The block does not track in-flight requests.
- `err` bits clear only on reset.
- No state machine per FIFO. Per-FIFO state:
  - read pointer and write pointer, log2(DEPTH) bits each, wrapping modulo DEPTH;
  - count, log2(DEPTH)+1 bits.

## Timing
- Write to visible: an entry written in cycle N is reflected in `wf_nonempty` and `wf_ready` in cycle N+1, and is readable by `rd_en` in cycle N+1.
- Read latency: 1 cycle, registered. `rd_instr`/`rd_pc` hold their last value when `rd_data_valid`=0.
- `wf_ready` and `wf_nonempty` are decoded combinationally from the registered counts.
- Reset state:
  - all counts and pointers 0;
  - `wf_ready` all ones, `wf_nonempty` 0;
  - `rd_data_valid` 0, `rd_instr` 0, `rd_pc` 0, `err` 0.
- Reset asserted mid-operation:
  - All queued entries are discarded.
  - A read issued in the cycle before reset produces no valid data.
  - Inputs sampled while `rst`=0 are ignored.
- Throughput: one write and one read per cycle, to any FIFOs.

## Structure
- Shared package/defines holds:
  - `NUM_WF`, `DEPTH`, `WFID_W`;
  - tag field positions (TAG_WFID_LO/HI, TAG_PC_LO/HI);
  - err bit indices.
- One natural sub-module: `wave_instr_fifo`.
  - Holds a single-wavefront DEPTH×64 FIFO with push, pop, flush, count, full and empty.
  - Instantiated NUM_WF times in a generate loop.
- Top level contains the wfid decode, the flush/write/read priority logic, the read mux and the output register.

## Test plan
- Reset then idle → `wf_ready`=8'hFF, `wf_nonempty`=0, `rd_data_valid`=0, `err`=0.
- Write instr 32'h0D0C0B0A, tag wfid=1, pc=32'h4; next cycle `rd_en`, wfid=1 → one cycle later `rd_data_valid`=1, `rd_instr`=32'h0D0C0B0A, `rd_pc`=32'h4, `wf_nonempty[1]`=0.
- Four writes to wf 2 (pcs 0, 4, 8, 12) → after the third, `wf_ready[2]`=0; a fifth write sets err[0]; four reads return pcs 0, 4, 8, 12 in order, exercising pointer wrap-around.
- Write to wf 3 and read of wf 3 (holding 1 entry) in the same cycle → the old entry is returned and count stays 1. A read of empty wf 5 → `rd_data_valid`=0 and err[1]=1.
- Fill wf 4 with 3 entries, then assert flush with a same-cycle write to wf 4 → next cycle `wf_nonempty[4]`=0, `wf_ready[4]`=1, `err`=0; wf 1 contents intact.
- Wave tag wfid=9 (≥ NUM_WF) → write dropped, err[0]=1; assert `rst`=0 with entries queued → all state and outputs return to reset values.

Source files
------------

// File: rtl/fetch_wavepool_pkg.sv
// Shared sizing, wave_tag field positions and error-bit indices for the
// per-wavefront instruction pool.
package fetch_wavepool_pkg;

  localparam int NUM_WF = 8;
  localparam int DEPTH  = 4;
  localparam int WFID_W = 6;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam int TAG_W       = 39;
  localparam int TAG_WFID_LO = 0;
  localparam int TAG_WFID_HI = 5;
  localparam int TAG_PC_LO   = 6;
  localparam int TAG_PC_HI   = 37;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/wave_instr_fifo.sv
// Single-wavefront instruction FIFO. The caller only asserts push when not
// full and pop when not empty; flush wins over both.
module wave_instr_fifo
  import fetch_wavepool_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  entry_t           wr_data,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // NOTE: rst is synchronous, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers alone decide validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_wavepool.sv
// Per-wavefront instruction queues between the instruction buffer and issue:
// wfid decode, flush/write/read priority, read mux and registered read port.
module fetch_wavepool
  import fetch_wavepool_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              fetchwave_ack,
  input  logic [31:0]       wave_instr,
  input  logic [TAG_W-1:0]  wave_tag,
  output logic [NUM_WF-1:0] wf_ready,
  output logic [NUM_WF-1:0] wf_nonempty,
  input  logic              rd_en,
  input  logic [WFID_W-1:0] rd_wfid,
  output logic              rd_data_valid,
  output logic [31:0]       rd_instr,
  output logic [31:0]       rd_pc,
  input  logic              flush_en,
  input  logic [WFID_W-1:0] flush_wfid,
  output logic [1:0]        err
);

  logic [WFID_W-1:0] wr_wfid;
  entry_t            wr_data;
  logic              unused_tag_rsv;

  assign wr_wfid        = wave_tag[TAG_WFID_HI:TAG_WFID_LO];
  assign wr_data.pc     = wave_tag[TAG_PC_HI:TAG_PC_LO];
  assign wr_data.instr  = wave_instr;
  assign unused_tag_rsv = wave_tag[TAG_W-1];

  logic [NUM_WF-1:0] push, pop, flush, full, empty;
  entry_t            head  [NUM_WF];
  logic [CNT_W-1:0]  count [NUM_WF];

  entry_t rd_sel;
  logic   ovf, udf;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ovf    = fetchwave_ack && (wr_wfid >= WFID_W'(NUM_WF));
    udf    = rd_en && (rd_wfid >= WFID_W'(NUM_WF));
    rd_sel = '0;
    push   = '0;
    pop    = '0;
    flush  = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      flush[i] = flush_en && (flush_wfid == WFID_W'(i));
      // A flushed wavefront swallows its same-cycle write and read silently.
      if (fetchwave_ack && (wr_wfid == WFID_W'(i)) && !flush[i]) begin
        push[i] = !full[i];
        if (full[i]) ovf = 1'b1;
      end
      if (rd_en && (rd_wfid == WFID_W'(i)) && !flush[i]) begin
        pop[i] = !empty[i];
        if (empty[i]) udf = 1'b1;
      end
      if (pop[i]) rd_sel = head[i];
    end
  end

  for (genvar g = 0; g < NUM_WF; g++) begin : g_fifo
    wave_instr_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push[g]),
      .pop     (pop[g]),
      .flush   (flush[g]),
      .wr_data (wr_data),
      .head    (head[g]),
      .count   (count[g]),
      .full    (full[g]),
      .empty   (empty[g])
    );

    assign wf_ready[g]    = (count[g] <= CNT_W'(DEPTH - 2));
    assign wf_nonempty[g] = !empty[g];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_valid <= 1'b0;
      rd_instr      <= '0;
      rd_pc         <= '0;
      err           <= '0;
    end else begin
      rd_data_valid <= |pop;
      if (|pop) begin
        rd_instr <= rd_sel.instr;
        rd_pc    <= rd_sel.pc;
      end
      if (ovf) err[ERR_OVF] <= 1'b1;
      if (udf) err[ERR_UDF] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_wavepool.sv
// Directed and random stimulus for fetch_wavepool against a queue-based
// reference model of the per-wavefront pool.
module tb_fetch_wavepool;
  import fetch_wavepool_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetchwave_ack;
  logic [31:0]       wave_instr;
  logic [TAG_W-1:0]  wave_tag;
  logic [NUM_WF-1:0] wf_ready;
  logic [NUM_WF-1:0] wf_nonempty;
  logic              rd_en;
  logic [WFID_W-1:0] rd_wfid;
  logic              rd_data_valid;
  logic [31:0]       rd_instr;
  logic [31:0]       rd_pc;
  logic              flush_en;
  logic [WFID_W-1:0] flush_wfid;
  logic [1:0]        err;

  always #5 clk = ~clk;

  fetch_wavepool dut (
    .clk           (clk),
    .rst           (rst),
    .fetchwave_ack (fetchwave_ack),
    .wave_instr    (wave_instr),
    .wave_tag      (wave_tag),
    .wf_ready      (wf_ready),
    .wf_nonempty   (wf_nonempty),
    .rd_en         (rd_en),
    .rd_wfid       (rd_wfid),
    .rd_data_valid (rd_data_valid),
    .rd_instr      (rd_instr),
    .rd_pc         (rd_pc),
    .flush_en      (flush_en),
    .flush_wfid    (flush_wfid),
    .err           (err)
  );

  // Reference model: one queue of {pc, instr} per wavefront plus output state.
  logic [63:0] q [NUM_WF][$];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic [1:0]  m_err;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NUM_WF-1:0] e_ready;
    logic [NUM_WF-1:0] e_nonempty;
    for (int i = 0; i < NUM_WF; i++) begin
      e_ready[i]    = (q[i].size() <= DEPTH - 2);
      e_nonempty[i] = (q[i].size() != 0);
    end
    check({tag, ".valid"},    64'(rd_data_valid), 64'(m_valid));
    check({tag, ".instr"},    64'(rd_instr),      64'(m_instr));
    check({tag, ".pc"},       64'(rd_pc),         64'(m_pc));
    check({tag, ".ready"},    64'(wf_ready),      64'(e_ready));
    check({tag, ".nonempty"}, 64'(wf_nonempty),   64'(e_nonempty));
    check({tag, ".err"},      64'(err),           64'(m_err));
  endtask

  task automatic idle_inputs();
    fetchwave_ack = 1'b0;
    wave_instr    = '0;
    wave_tag      = '0;
    rd_en         = 1'b0;
    rd_wfid       = '0;
    flush_en      = 1'b0;
    flush_wfid    = '0;
  endtask

  // One clock with the given inputs; the model is advanced from the pre-edge state.
  task automatic step(input logic a, input logic [31:0] ins, input logic [31:0] pc,
                      input int wid, input logic re, input int rid,
                      input logic fe, input int fid, input logic rsv, input string tag);
    bit fl;
    bit do_push;
    logic [63:0] e;
    fetchwave_ack = a;
    wave_instr    = ins;
    wave_tag      = {rsv, pc, WFID_W'(wid)};
    rd_en         = re;
    rd_wfid       = WFID_W'(rid);
    flush_en      = fe;
    flush_wfid    = WFID_W'(fid);

    fl      = fe && (fid < NUM_WF);
    do_push = 1'b0;
    if (a) begin
      if (wid >= NUM_WF)                 m_err[0] = 1'b1;
      else if (fl && fid == wid)         do_push = 1'b0;
      else if (q[wid].size() == DEPTH)   m_err[0] = 1'b1;
      else                               do_push = 1'b1;
    end
    m_valid = 1'b0;
    if (re) begin
      if (rid >= NUM_WF)                 m_err[1] = 1'b1;
      else if (fl && fid == rid)         m_valid = 1'b0;
      else if (q[rid].size() == 0)       m_err[1] = 1'b1;
      else begin
        e       = q[rid].pop_front();
        m_valid = 1'b1;
        m_pc    = e[63:32];
        m_instr = e[31:0];
      end
    end
    if (do_push) q[wid].push_back({pc, ins});
    if (fl) q[fid].delete();

    @(posedge clk);
    #1;
    idle_inputs();
    check_all(tag);
  endtask

  task automatic wr(input int wid, input logic [31:0] ins, input logic [31:0] pc, input string tag);
    step(1'b1, ins, pc, wid, 1'b0, 0, 1'b0, 0, 1'b0, tag);
  endtask

  task automatic rd(input int rid, input string tag);
    step(1'b0, '0, '0, 0, 1'b1, rid, 1'b0, 0, 1'b0, tag);
  endtask

  // Reset with garbage on the inputs, which must be ignored.
  task automatic do_reset(input string tag);
    rst           = 1'b0;
    fetchwave_ack = 1'b1;
    wave_instr    = $urandom;
    wave_tag      = {7'($urandom), 32'($urandom)};
    rd_en         = 1'b1;
    rd_wfid       = WFID_W'($urandom_range(0, NUM_WF - 1));
    flush_en      = 1'b0;
    flush_wfid    = '0;
    for (int i = 0; i < NUM_WF; i++) q[i].delete();
    m_valid = 1'b0;
    m_instr = '0;
    m_pc    = '0;
    m_err   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all(tag);
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, "_idle"});
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_reset("reset");
    check("reset.ready_ff", 64'(wf_ready), 64'hFF);

    // Single write then read on wf 1.
    wr(1, 32'h0D0C0B0A, 32'h4, "wr1");
    rd(1, "rd1");
    check("rd1.instr_const", 64'(rd_instr), 64'h0D0C0B0A);
    check("rd1.nonempty1", 64'(wf_nonempty[1]), 64'h0);

    // Flush beats a same-cycle write; wf 1 holds an entry that must survive.
    wr(1, 32'hAAAA0001, 32'h100, "wr1b");
    for (int i = 0; i < 3; i++) wr(4, 32'h44440000 + i, 32'h40 + 4 * i, $sformatf("fill4_%0d", i));
    step(1'b1, 32'hDEADBEEF, 32'h50, 4, 1'b0, 0, 1'b1, 4, 1'b0, "flush4");
    check("flush4.ready4", 64'(wf_ready[4]), 64'h1);
    check("flush4.err0", 64'(err), 64'h0);
    step(1'b0, '0, '0, 0, 1'b1, 4, 1'b1, 4, 1'b0, "flush4_rd");
    rd(1, "rd1_intact");

    // Fill wf 2, overflow, then drain across the pointer wrap.
    for (int i = 0; i < 4; i++) begin
      wr(2, 32'h22220000 + i, 32'(4 * i), $sformatf("fill2_%0d", i));
      if (i == 2) check("fill2.ready2_low", 64'(wf_ready[2]), 64'h0);
    end
    wr(2, 32'h2222FFFF, 32'h10, "ovf2");
    for (int i = 0; i < 4; i++) begin
      rd(2, $sformatf("drain2_%0d", i));
      check($sformatf("drain2_pc_%0d", i), 64'(rd_pc), 64'(4 * i));
    end

    // Same-cycle push and pop on wf 3 holding one entry; then empty-read of wf 5.
    wr(3, 32'h33330000, 32'h300, "wr3");
    step(1'b1, 32'h33330001, 32'h304, 3, 1'b1, 3, 1'b0, 0, 1'b0, "pushpop3");
    check("pushpop3.pc", 64'(rd_pc), 64'h300);
    rd(5, "udf5");
    check("udf5.err1", 64'(err[1]), 64'h1);
    // Same-cycle push and pop on empty wf 6: underflow, but the push lands.
    step(1'b1, 32'h66660000, 32'h600, 6, 1'b1, 6, 1'b0, 0, 1'b0, "pushpop6");

    // Out-of-range write id, then reset with entries queued.
    wr(9, 32'h99990000, 32'h900, "badwr");
    check("badwr.err0", 64'(err[0]), 64'h1);
    do_reset("reset_mid");

    // Randomized traffic including bad ids, flushes and the reserved tag bit.
    for (int n = 0; n < 600; n++) begin
      int wid, rid, fid;
      wid = ($urandom_range(0, 15) == 0) ? $urandom_range(NUM_WF, 63) : $urandom_range(0, NUM_WF - 1);
      rid = ($urandom_range(0, 15) == 0) ? $urandom_range(NUM_WF, 63) : $urandom_range(0, NUM_WF - 1);
      fid = $urandom_range(0, NUM_WF);
      step(1'($urandom_range(0, 2) != 0), $urandom, $urandom, wid,
           1'($urandom_range(0, 1)), rid, 1'($urandom_range(0, 11) == 0), fid,
           1'($urandom), $sformatf("rnd%0d", n));
      if (n == 300) do_reset("reset_rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
